relu_vector_buffer: RTL and testbench

- Directly downstream of the first-stage quadrant accumulator.
- Captures each z_element pulse and applies ReLU to the low 16 bits, which are treated as signed two's complement.
- Buffers the results in a FIFO and replays them over a valid/ready stream to the next layer.
- Tags every VECTOR_LEN-th element as last, so the next stage's last_element can be driven directly.

---
 rtl/nn_stage_pkg.sv | 23 ++
 rtl/stage_fifo_mem.sv | 32 +++
 rtl/relu_vector_buffer.sv | 133 +++++++++++++
 tb/tb_relu_vector_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_stage_pkg.sv
// Shared definitions for the NN stage datapath.
//   ELEM_W      : element width
//   LEAKY_SHIFT : right shift applied to negative inputs in the leaky build
//   element_t   : signed element type
//   relu_fn     : activation. Build option LEAKY_RELU_EN selects leaky ReLU
//                 (negative -> x >>> LEAKY_SHIFT); otherwise negative -> 0.
package nn_stage_pkg;

  localparam int unsigned ELEM_W      = 16;
  localparam int unsigned LEAKY_SHIFT = 3;

  typedef logic signed [ELEM_W-1:0] element_t;

  function automatic element_t relu_fn(input element_t x);
`ifdef LEAKY_RELU_EN
    // Arithmetic shift keeps the sign, so small negatives saturate at -1.
    return x[ELEM_W-1] ? (x >>> LEAKY_SHIFT) : x;
`else
    return x[ELEM_W-1] ? element_t'(0) : x;
`endif
  endfunction

endpackage

// File: rtl/stage_fifo_mem.sv
// Storage array for the stage FIFO: synchronous write, combinational read,
// no reset (contents are meaningless until written).
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module stage_fifo_mem #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 17,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_vector_buffer.sv
// ReLU vector buffer: captures each z_element strobe, applies ReLU to it,
// queues {last_tag, value} in a first-word fall-through FIFO and replays the
// queue over a valid/ready stream. Every VECTOR_LEN-th strobe is tagged last.
// Build option LEAKY_RELU_EN switches to leaky ReLU (see nn_stage_pkg).
//   clock           : rising-edge clock
//   clear_n         : asynchronous active-low reset
//   flush           : synchronous clear of pointers, counters and overflow
//   z_element       : upstream value
//   z_element_ready : single-cycle strobe qualifying z_element
//   out_element     : head-of-FIFO data
//   out_valid       : FIFO not empty
//   out_ready       : consumer accepts head this cycle
//   out_last        : head element closes a vector
//   fill_level      : occupied entries, 0..DEPTH
//   overflow        : sticky, an element was dropped
module relu_vector_buffer
  import nn_stage_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,  // power of two, >= 2
  parameter int unsigned VECTOR_LEN = 4,  // >= 1
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                flush,
  input  logic [ELEM_W-1:0]   z_element,
  input  logic                z_element_ready,
  output logic [ELEM_W-1:0]   out_element,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [PTR_W:0]      fill_level,
  output logic                overflow
);

  localparam int unsigned VC_W   = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int unsigned WORD_W = ELEM_W + 1;

  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [VC_W-1:0] VC_LAST  = VC_W'(VECTOR_LEN - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [VC_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic             overflow_q, overflow_d;

  logic              full;
  logic              rd_fire;
  logic              wr_en;
  logic              drop;
  logic              vec_last;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  assign full     = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign rd_fire  = out_valid && out_ready;
  // A read at full frees a slot in the same cycle, so the write still lands.
  assign wr_en    = z_element_ready && (!full || rd_fire);
  assign drop     = z_element_ready && full && !rd_fire;
  assign vec_last = (vec_cnt_q == VC_LAST);
  assign wr_word  = {vec_last, relu_fn(z_element)};

  stage_fifo_mem #(
    .Depth (DEPTH),
    .Width (WORD_W)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (wr_en && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    vec_cnt_d  = vec_cnt_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      vec_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_fire})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
      // Dropped strobes still count so vector alignment survives overflow.
      if (z_element_ready) begin
        vec_cnt_d = vec_last ? '0 : vec_cnt_q + VC_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vec_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vec_cnt_q  <= vec_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_element = rd_word[ELEM_W-1:0];
  // Gated so stale or unwritten memory never shows a tag while empty.
  assign out_last    = out_valid && rd_word[ELEM_W];
  assign fill_level  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_relu_vector_buffer.sv
module tb_relu_vector_buffer;

  localparam int DEPTH      = 8;
  localparam int VECTOR_LEN = 4;

  logic        clock;
  logic        clear_n;
  logic        flush;
  logic [15:0] z_element;
  logic        z_element_ready;
  logic [15:0] out_element;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  fill_level;
  logic        overflow;

  relu_vector_buffer #(
    .DEPTH      (DEPTH),
    .VECTOR_LEN (VECTOR_LEN)
  ) dut (
    .clock           (clock),
    .clear_n         (clear_n),
    .flush           (flush),
    .z_element       (z_element),
    .z_element_ready (z_element_ready),
    .out_element     (out_element),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .fill_level      (fill_level),
    .overflow        (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {last, value}, element index within vector, sticky drop flag.
  logic [16:0] m_q[$];
  int          m_vc;
  bit          m_ovf;

  function automatic logic [15:0] ref_relu(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v >= 0) return x;
`ifdef LEAKY_RELU_EN
    // floor(v / 8) for negative v
    return 16'(-((-v + 7) / 8));
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_vc  = 0;
    m_ovf = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cycle(input logic stb, input logic [15:0] d, input logic rdy, input logic fl);
    bit rd;
    z_element_ready = stb;
    z_element       = d;
    out_ready       = rdy;
    flush           = fl;
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else begin
      rd = (m_q.size() > 0) && rdy;
      if (rd) void'(m_q.pop_front());
      if (stb) begin
        if (m_q.size() < DEPTH) m_q.push_back({(m_vc == VECTOR_LEN - 1), ref_relu(d)});
        else m_ovf = 1;
        m_vc = (m_vc + 1) % VECTOR_LEN;
      end
    end
    #1;
    z_element_ready = 1'b0;
    flush           = 1'b0;
    out_ready       = 1'b0;
  endtask

  task automatic do_flush();
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    flush = 1'b0; z_element = '0; z_element_ready = 1'b0; out_ready = 1'b0;
    model_clear();
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if (fill_level !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    clear_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic_relu();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0005;
`ifdef LEAKY_RELU_EN
    exp_seq[1] = 16'hF000;
`else
    exp_seq[1] = 16'h0000;
`endif
    exp_seq[2] = 16'h7FFF;
    do_flush();
    cycle(1'b1, 16'h0005, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_element !== 16'h0005) begin
      errors++;
      $display("FAIL basic_latency got v=%b d=%h want v=1 d=0005", out_valid, out_element);
    end
    cycle(1'b1, 16'h8001, 1'b0, 1'b0);
    cycle(1'b1, 16'h7FFF, 1'b0, 1'b0);
    checks++;
    if (fill_level !== 4'd3) begin errors++; $display("FAIL basic_fill got %0d want 3", fill_level); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_element !== exp_seq[i]) begin
        errors++;
        $display("FAIL basic_order[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_element,
                 exp_seq[i]);
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b want 0", out_valid); end
  endtask

  task automatic test_vector_tag();
    do_flush();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_last !== ((i % 4) == 3) || out_element !== m_q[0][15:0]) begin
        errors++;
        $display("FAIL tag[%0d] got v=%b last=%b d=%h want v=1 last=%b d=%h", i, out_valid,
                 out_last, out_element, ((i % 4) == 3), m_q[0][15:0]);
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ninth;
    do_flush();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(i + 16'h0100), 1'b0, 1'b0);
    ninth = 16'h1234;
    cycle(1'b1, ninth, 1'b0, 1'b0);
    checks++;
    if (fill_level !== 4'd8) begin errors++; $display("FAIL ovf_fill got %0d want 8", fill_level); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_element !== 16'(i + 16'h0100) || out_element === ninth) begin
        errors++;
        $display("FAIL ovf_drain[%0d] got %h want %h", i, out_element, 16'(i + 16'h0100));
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain got v=%b ovf=%b want v=0 ovf=1", out_valid, overflow);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_last !== (i == 2)) begin
        errors++;
        $display("FAIL ovf_align[%0d] got last=%b want %b", i, out_last, (i == 2));
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full_rw();
    do_flush();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0ABC, 1'b1, 1'b0);
    checks++;
    if (fill_level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw got fill=%0d ovf=%b want fill=8 ovf=0", fill_level, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_element !== ((i == 7) ? 16'h0ABC : 16'(16'h0301 + i))) begin
        errors++;
        $display("FAIL full_rw_order[%0d] got %h want %h", i, out_element,
                 ((i == 7) ? 16'h0ABC : 16'(16'h0301 + i)));
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_flush_mid();
    do_flush();
    for (int i = 0; i < 9; i++) cycle(1'b1, 16'($urandom_range(0, 16'h7FFF)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if (fill_level !== 4'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got fill=%0d ovf=%b want fill=5 ovf=1", fill_level, overflow);
    end
    #2;
    clear_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b fill=%0d ovf=%b want 0 0 0", out_valid, fill_level,
               overflow);
    end
    #1;
    clear_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 9; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'h0777, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush got v=%b fill=%0d ovf=%b want 0 0 0", out_valid, fill_level, overflow);
    end
    // After flush the vector counter restarts: 4th new strobe closes the vector.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_last !== (i == 3) || out_element !== 16'(16'h0400 + i)) begin
        errors++;
        $display("FAIL flush_realign[%0d] got last=%b d=%h want last=%b d=%h", i, out_last,
                 out_element, (i == 3), 16'(16'h0400 + i));
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    do_flush();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) == 0));
      checks++;
      if (out_valid !== (m_q.size() > 0) || fill_level !== 4'(m_q.size()) ||
          overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_state[%0d] got v=%b fill=%0d ovf=%b want v=%b fill=%0d ovf=%b", n,
                 out_valid, fill_level, overflow, (m_q.size() > 0), m_q.size(), m_ovf);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (out_element !== m_q[0][15:0] || out_last !== m_q[0][16]) begin
          errors++;
          $display("FAIL rand_head[%0d] got d=%h last=%b want d=%h last=%b", n, out_element,
                   out_last, m_q[0][15:0], m_q[0][16]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_relu();
    test_vector_tag();
    test_overflow();
    test_full_rw();
    test_reset_flush_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
